data_memory_hs: RTL and testbench

DATA_MEMORY_HS -- requirements
Module: data_memory_hs

---
 rtl/data_memory_pkg.sv | 20 ++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/data_memory_hs.sv | 154 +++++++++++++++
 tb/tb_data_memory_hs.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - FUNC3 load/store encodings and FSM state type for data_memory_hs.
package data_memory_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational byte-lane steering: load extraction/extension, store replication, byte enables.
module mem_lane_align
  import data_memory_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  byte_en
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rd_word[{byte_off, 3'b000} +: 8];
  assign sel_half = rd_word[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    load_data = 32'h0;
    case (func3)
      F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      F3_LW:   load_data = rd_word;
      F3_LBU:  load_data = {24'h0, sel_byte};
      F3_LHU:  load_data = {16'h0, sel_half};
      default: load_data = 32'h0;
    endcase
  end

  // Data is replicated across lanes so only the enables need the offset.
  always_comb begin
    store_data = wr_data;
    byte_en    = 4'b0000;
    case (func3)
      F3_SB: begin
        store_data = {4{wr_data[7:0]}};
        byte_en    = 4'b0001 << byte_off;
      end
      F3_SH: begin
        store_data = {2{wr_data[15:0]}};
        byte_en    = 4'b0011 << byte_off;
      end
      F3_SW: begin
        store_data = wr_data;
        byte_en    = 4'b1111;
      end
      default: begin
        store_data = wr_data;
        byte_en    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - RV32I data memory with BUSY/DONE handshake, wait states and fault reporting.
module data_memory_hs
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MRd,
  input  logic        MWrt,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDR,
  input  logic [31:0] W_DATA,
  output logic [31:0] R_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAULT
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD   = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        rd_q, wr_q, fault_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp, req_fault, bad_code, misaligned;
  logic        cur_rd, cur_wr;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wdata, rd_word, load_data, store_data;
  logic [3:0]  byte_en;
  logic [AW-1:0] word_idx;

  assign accept     = (state == IDLE) && (MRd || MWrt);
  assign enter_resp = (accept && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd0);

  // With no wait states the request completes on its accepting edge, so the live inputs stand in for the latches.
  always_comb begin
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    cur_f3    = f3_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_rd    = MRd;
      cur_wr    = MWrt;
      cur_f3    = FUNC3;
      cur_addr  = ADDR;
      cur_wdata = W_DATA;
    end
  end

  always_comb begin
    bad_code   = 1'b0;
    misaligned = 1'b0;
    if (cur_rd && !cur_wr) begin
      case (cur_f3)
        F3_LB, F3_LBU: misaligned = 1'b0;
        F3_LH, F3_LHU: misaligned = cur_addr[0];
        F3_LW:         misaligned = (cur_addr[1:0] != 2'b00);
        default:       bad_code   = 1'b1;
      endcase
    end else if (cur_wr && !cur_rd) begin
      case (cur_f3)
        F3_SB:   misaligned = 1'b0;
        F3_SH:   misaligned = cur_addr[0];
        F3_SW:   misaligned = (cur_addr[1:0] != 2'b00);
        default: bad_code   = 1'b1;
      endcase
    end else begin
      bad_code = 1'b1;
    end
    req_fault = bad_code || misaligned || (cur_addr >= ADDR_LIMIT);
  end

  assign word_idx = cur_addr[AW+1:2];
  assign rd_word  = mem[word_idx];

  mem_lane_align u_align (
    .func3      (cur_f3),
    .byte_off   (cur_addr[1:0]),
    .rd_word    (rd_word),
    .wr_data    (cur_wdata),
    .load_data  (load_data),
    .store_data (store_data),
    .byte_en    (byte_en)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY  = (state != IDLE);
    DONE  = (state == RESP);
    FAULT = (state == RESP) && fault_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt     <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        rd_q    <= MRd;
        wr_q    <= MWrt;
        f3_q    <= FUNC3;
        addr_q  <= ADDR;
        wdata_q <= W_DATA;
        cnt     <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        fault_q <= req_fault;
        if (cur_rd && !req_fault) rdata_q <= load_data;
      end
    end
  end

  // Storage is never reset; a reset edge only suppresses the commit.
  always_ff @(posedge CLK) begin
    if (RESET && enter_resp && cur_wr && !req_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  assign R_DATA = rdata_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// tb/tb_data_memory_hs.sv - scoreboard bench for data_memory_hs with a byte-array reference model.
module tb_data_memory_hs;
  import data_memory_pkg::*;

  localparam int DEPTH = 16;
  localparam int WS    = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET;
  logic        mrd, mwrt, busy, done, fault;
  logic [2:0]  func3;
  logic [31:0] addr, w_data, r_data;
  logic        z_mrd, z_mwrt, z_busy, z_done, z_fault;
  logic [2:0]  z_f3;
  logic [31:0] z_addr, z_wdata, z_rdata;

  data_memory_hs #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .RESET(RESET), .MRd(mrd), .MWrt(mwrt), .FUNC3(func3), .ADDR(addr),
    .W_DATA(w_data), .R_DATA(r_data), .BUSY(busy), .DONE(done), .FAULT(fault)
  );

  data_memory_hs #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .MRd(z_mrd), .MWrt(z_mwrt), .FUNC3(z_f3), .ADDR(z_addr),
    .W_DATA(z_wdata), .R_DATA(z_rdata), .BUSY(z_busy), .DONE(z_done), .FAULT(z_fault)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [7:0]  mb [0:4*DEPTH-1];
  logic [31:0] m_rdata;

  // Reference: memory as a flat byte array, access size 1/2/4 from FUNC3[1:0].
  task automatic model_step(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, output logic flt);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    flt = 1'b0;
    if (rd == wr) flt = 1'b1;
    else if (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) flt = 1'b1;
    else if (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) flt = 1'b1;
    if (!flt && (((a % size) != 0) || (a >= 4 * DEPTH))) flt = 1'b1;
    if (!flt && wr) for (int i = 0; i < size; i++) mb[a + i] = wd[8*i +: 8];
    if (!flt && rd) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[a + i];
      if (!f3[2] && size < 4 && v[8*size-1]) for (int k = 8 * size; k < 32; k++) v[k] = 1'b1;
      m_rdata = v;
    end
  endtask

  task automatic clear_inputs();
    mrd = 1'b0; mwrt = 1'b0; func3 = 3'b000; addr = 32'h0; w_data = 32'h0;
  endtask

  // mode 0: normal, 1: reset during WAIT, 2: reset during RESP. Called at a negedge with the DUT idle.
  task automatic do_req(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int mode);
    logic flt;
    int n;
    mrd = rd; mwrt = wr; func3 = f3; addr = a; w_data = wd;
    if (mode != 1) begin
      model_step(rd, wr, f3, a, wd, flt);
      sb_q.push_back('{flt, m_rdata, name});
    end
    @(posedge CLK);
    #1;
    mrd = 1'($urandom); mwrt = 1'($urandom); func3 = 3'($urandom);
    addr = $urandom_range(0, 4 * DEPTH + 7); w_data = $urandom;
    n = 0;
    forever begin
      @(negedge CLK);
      n++;
      chk({name, "_busy"}, 32'(busy), 32'd1);
      if (mode == 1) begin
        RESET = 1'b0;
        clear_inputs();
        @(negedge CLK);
        RESET = 1'b1;
        chk({name, "_rst_busy"}, 32'(busy), 32'd0);
        chk({name, "_rst_rdata"}, r_data, 32'h0);
        m_rdata = 32'h0;
        repeat (WS + 2) @(negedge CLK);
        return;
      end
      if (done === 1'b1 || n > 20) break;
    end
    chk({name, "_latency"}, n, WS + 1);
    clear_inputs();
    if (mode == 2) begin
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      chk({name, "_rst_rdata"}, r_data, 32'h0);
      m_rdata = 32'h0;
    end else begin
      @(negedge CLK);
    end
    chk({name, "_idle"}, {busy, done}, 32'd0);
  endtask

  always @(negedge CLK) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        mon_e = sb_q.pop_front();
        chk({mon_e.name, "_fault"}, 32'(fault), 32'(mon_e.fault));
        chk({mon_e.name, "_rdata"}, r_data, mon_e.rdata);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v0;
    int r;
    RESET = 1'b0;
    clear_inputs();
    z_mrd = 1'b0; z_mwrt = 1'b0; z_f3 = 3'b000; z_addr = 32'h0; z_wdata = 32'h0;
    m_rdata = 32'h0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", r_data, 32'h0);
    chk("rst0_flags", {z_busy, z_done, z_fault}, 32'd0);
    chk("rst0_rdata", z_rdata, 32'h0);
    RESET = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < DEPTH; i++) do_req("init", 1'b0, 1'b1, F3_SW, 32'(4 * i), $urandom, 0);

    do_req("sw10", 1'b0, 1'b1, F3_SW, 32'h10, 32'hDEADBEEF, 0);
    do_req("lb13", 1'b1, 1'b0, F3_LB, 32'h13, 32'h0, 0);
    chk("lb13_val", r_data, 32'hFFFFFFDE);
    do_req("lbu13", 1'b1, 1'b0, F3_LBU, 32'h13, 32'h0, 0);
    chk("lbu13_val", r_data, 32'h000000DE);
    do_req("lh10", 1'b1, 1'b0, F3_LH, 32'h10, 32'h0, 0);
    chk("lh10_val", r_data, 32'hFFFFBEEF);
    do_req("lhu12", 1'b1, 1'b0, F3_LHU, 32'h12, 32'h0, 0);
    chk("lhu12_val", r_data, 32'h0000DEAD);
    do_req("sb11", 1'b0, 1'b1, F3_SB, 32'h11, 32'h000000F0, 0);
    do_req("lw10", 1'b1, 1'b0, F3_LW, 32'h10, 32'h0, 0);
    chk("lw10_val", r_data, 32'hDEADF0EF);

    do_req("lw12_flt", 1'b1, 1'b0, F3_LW, 32'h12, 32'h0, 0);
    do_req("sh11_flt", 1'b0, 1'b1, F3_SH, 32'h11, 32'h00001234, 0);
    do_req("lw_oob", 1'b1, 1'b0, F3_LW, 32'(4 * DEPTH), 32'h0, 0);
    do_req("sw_oob", 1'b0, 1'b1, F3_SW, 32'(4 * DEPTH), 32'h55555555, 0);
    do_req("both_flt", 1'b1, 1'b1, F3_SW, 32'h10, 32'h11111111, 0);
    chk("flt_rdata_hold", r_data, 32'hDEADF0EF);
    do_req("lw10_again", 1'b1, 1'b0, F3_LW, 32'h10, 32'h0, 0);
    chk("lw10_again_val", r_data, 32'hDEADF0EF);
    do_req("lw00_after_oob", 1'b1, 1'b0, F3_LW, 32'h0, 32'h0, 0);

    do_req("sw20_abort", 1'b0, 1'b1, F3_SW, 32'h20, 32'h12345678, 1);
    do_req("lw20", 1'b1, 1'b0, F3_LW, 32'h20, 32'h0, 0);
    do_req("sw24_rresp", 1'b0, 1'b1, F3_SW, 32'h24, 32'hCAFEF00D, 2);
    do_req("lw24", 1'b1, 1'b0, F3_LW, 32'h24, 32'h0, 0);
    chk("lw24_val", r_data, 32'hCAFEF00D);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      do_req("rnd", (r < 5 || r == 9), (r >= 5), 3'($urandom_range(0, 7)),
             $urandom_range(0, 4 * DEPTH + 7), $urandom, 0);
    end

    v0 = $urandom;
    z_mwrt = 1'b1; z_f3 = F3_SW; z_addr = 32'h0; z_wdata = v0;
    @(negedge CLK);
    chk("z_sw_done", 32'(z_done), 32'd1);
    chk("z_sw_fault", 32'(z_fault), 32'd0);
    z_mwrt = 1'b0;
    @(negedge CLK);
    chk("z_sw_idle", 32'(z_busy), 32'd0);
    z_mrd = 1'b1; z_f3 = F3_LW; z_addr = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk("z_b2b_done", 32'(z_done), 32'(i % 2 == 0));
      chk("z_b2b_busy", 32'(z_busy), 32'(z_done));
      if (z_done === 1'b1) begin
        chk("z_b2b_rdata", z_rdata, v0);
        chk("z_b2b_fault", 32'(z_fault), 32'd0);
      end
      z_addr = (z_done === 1'b1) ? 32'h2 : 32'h0;
    end
    z_mrd = 1'b0;
    @(negedge CLK);

    chk("sb_drain", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
